// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if
// Request/response bus between the load/store stage and the data memory.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_wr              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and per-byte enables
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata/rsp_err   : load data (0 for stores/errors) and error flag
// master = requester (core), slave = memory.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
// Word-addressed data memory for the load/store stage with a valid/ready
// request port, registered one-cycle responses, byte enables, an error
// response for misaligned or out-of-range accesses, and a multi-cycle zero
// sweep that runs after reset and on demand.
// Ports:
//   clock  : single rising-edge clock
//   reset  : synchronous, active-high; restarts the sweep at word 0
//   clear  : request a full zero sweep (honoured only while running)
//   bus    : dmem_ctrl_if slave port (request/response handshake)
//   busy   : a sweep is in progress (inverse of req_ready)
//   debug  : low DBG_BITS of words 0..DBG_WORDS-1, word 0 in the LSBs
module dmem_ctrl #(
  parameter int DEPTH     = 128,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DBG_WORDS = 8,
  parameter int DBG_BITS  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  dmem_ctrl_if.slave                    bus,
  output logic                          busy,
  output logic [DBG_WORDS*DBG_BITS-1:0] debug
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;

  logic              rdy;
  logic              sweep_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word;
  logic [IDX_W-1:0]  widx;
  logic              err;
  logic              acc;
  logic              st_we;

  logic              rsp_vld_p1;
  logic              rsp_err_p1;
  logic [DATA_W-1:0] rsp_rdata_p1;

  // State register: sweep index travels with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic. A clear seen during a sweep is ignored so the sweep is
  // never extended; the last word is written in the cycle that leaves CLEAR.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      CLEAR: begin
        idx_nx = idx + 1'b1;
        if (idx == IDX_W'(DEPTH - 1)) begin
          state_nx = RUN;
          idx_nx   = '0;
        end
      end
      RUN: begin
        if (clear) begin
          state_nx = CLEAR;
          idx_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        idx_nx   = '0;
      end
    endcase
  end

  // Output logic: ready depends on state alone.
  always_comb begin
    rdy      = (state == RUN);
    busy     = (state == CLEAR);
    sweep_we = (state == CLEAR) && !reset;
  end

  assign bus.req_ready = rdy;

  // Address decode. The range check uses the full address width so high
  // address bits can never alias onto a valid word.
  always_comb begin
    word  = bus.req_addr >> OFF_W;
    widx  = word[IDX_W-1:0];
    err   = ((bus.req_addr & ADDR_W'(BE_W - 1)) != '0) ||
            (word >= ADDR_W'(DEPTH));
    acc   = bus.req_valid && rdy && !reset;
    st_we = acc && bus.req_wr && !err;
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[idx] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.req_be[b]) mem[widx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  // Response stage p1. Data is cleared on reset too so the bus reads 0
  // whenever no response is valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_vld_p1   <= 1'b0;
      rsp_err_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
    end else begin
      rsp_vld_p1   <= acc;
      rsp_err_p1   <= acc && err;
      rsp_rdata_p1 <= (acc && !bus.req_wr && !err) ? mem[widx] : '0;
    end
  end

  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_err   = rsp_err_p1;
  assign bus.rsp_rdata = rsp_rdata_p1;

  always_comb begin
    debug = '0;
    for (int i = 0; i < DBG_WORDS; i++) begin
      debug[i*DBG_BITS +: DBG_BITS] = mem[i][DBG_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl
// Randomised and directed stimulus for dmem_ctrl, checked against a
// behavioural model: a word array, a count of sweep cycles still to run and
// the response expected for the request presented in each cycle.
module tb_dmem_ctrl;
  localparam int DEPTH     = 128;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int DBG_WORDS = 8;
  localparam int DBG_BITS  = 4;
  localparam int BE_W      = DATA_W / 8;

  logic clock = 1'b0;
  logic reset;
  logic clear;
  logic busy;
  logic [DBG_WORDS*DBG_BITS-1:0] debug;

  dmem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_ctrl #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .DBG_WORDS(DBG_WORDS), .DBG_BITS(DBG_BITS)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .bus(bus), .busy(busy), .debug(debug)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem_m [DEPTH];
  int  sweep_left;
  bit  mem_known;
  bit  exp_vld;
  bit  exp_err;
  logic [DATA_W-1:0] exp_rdata;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DBG_WORDS*DBG_BITS-1:0] dbg_model();
    logic [DBG_WORDS*DBG_BITS-1:0] d;
    d = '0;
    for (int i = 0; i < DBG_WORDS; i++) d[i*DBG_BITS +: DBG_BITS] = mem_m[i][DBG_BITS-1:0];
    return d;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input bit rst_v, input bit clr_v, input bit vld, input bit wr,
                     input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                     input logic [BE_W-1:0] be);
    bit ready_m;
    bit e;
    int w;
    ready_m = (sweep_left == 0);
    chk("req_ready", bus.req_ready, ready_m);
    chk("busy", busy, !ready_m);
    if (mem_known) chk("debug", debug, dbg_model());

    reset = rst_v; clear = clr_v;
    bus.req_valid = vld; bus.req_wr = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_be = be;

    exp_vld = 0; exp_err = 0; exp_rdata = '0;
    if (rst_v) begin
      sweep_left = DEPTH;
    end else if (!ready_m) begin
      mem_m[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (vld) begin
        e = (addr % BE_W != 0) || ((addr / BE_W) >= DEPTH);
        exp_vld = 1; exp_err = e;
        if (!e) begin
          w = int'(addr / BE_W);
          if (wr) begin
            for (int b = 0; b < BE_W; b++)
              if (be[b]) mem_m[w][8*b +: 8] = wdata[8*b +: 8];
          end else begin
            exp_rdata = mem_m[w];
          end
        end
      end
      if (clr_v) sweep_left = DEPTH;
    end

    @(posedge clock);
    @(negedge clock);
    chk("rsp_valid", bus.rsp_valid, exp_vld);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic ld(input logic [ADDR_W-1:0] a);
    cyc(0, 0, 1, 0, a, '0, '0);
  endtask

  task automatic st(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    cyc(0, 0, 1, 1, a, d, be);
  endtask

  // Counts busy cycles until ready; optionally pulses clear at cycle clr_at.
  task automatic wait_ready(input int clr_at, output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (!busy) break;
      n++;
      cyc(0, (k == clr_at), 0, 0, '0, '0, '0);
    end
  endtask

  initial begin
    int n;
    int r;
    logic [ADDR_W-1:0] a;

    reset = 1; clear = 0;
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0;
    mem_known = 0;
    @(negedge clock);
    @(negedge clock);
    sweep_left = DEPTH;
    chk("rst_busy", busy, 1);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    cyc(1, 0, 0, 0, '0, '0, '0);
    wait_ready(-1, n);
    chk("init_sweep_len", n, DEPTH);
    mem_known = 1;

    // Last word is cleared by the sweep.
    st(32'h1FC, 32'hDEADBEEF, 4'hF);
    cyc(1, 0, 0, 0, '0, '0, '0);
    wait_ready(-1, n);
    chk("reset_sweep_len", n, DEPTH);
    ld(32'h1FC);
    chk("last_word_clr", bus.rsp_rdata, 32'h0);

    // Byte enables.
    st(32'h10, 32'hAABBCCDD, 4'hF);
    st(32'h10, 32'h11223344, 4'b0101);
    ld(32'h10);
    chk("byte_en", bus.rsp_rdata, 32'hAA22CC44);
    st(32'h10, 32'hFFFFFFFF, 4'h0);
    ld(32'h10);

    // Errors.
    ld(32'h200);
    chk("err_oor", bus.rsp_err, 1);
    st(32'h0, 32'h0BADF00D, 4'hF);
    st(32'h202, 32'h12345678, 4'hF);
    chk("err_misal", bus.rsp_err, 1);
    ld(32'h0);
    ld(32'h1FC);
    ld(32'h8000_0004);
    chk("err_highbit", bus.rsp_err, 1);
    ld(32'h13);

    // Back-to-back store then load.
    st(32'h0, 32'h5, 4'hF);
    chk("b2b_first", bus.rsp_valid, 1);
    ld(32'h0);
    chk("b2b_second", bus.rsp_valid, 1);
    chk("b2b_data", bus.rsp_rdata, 32'h5);
    chk("dbg_nib", debug[3:0], 4'h5);

    // Clear alongside an accepted load.
    cyc(0, 1, 1, 0, 32'h10, '0, '0);
    chk("clr_load_rsp", bus.rsp_valid, 1);
    wait_ready(-1, n);
    chk("clr_sweep_len", n, DEPTH);

    // Reset with a response pending.
    st(32'h8, 32'hCAFE0001, 4'hF);
    ld(32'h8);
    cyc(1, 0, 0, 0, '0, '0, '0);
    chk("rst_drop_rsp", bus.rsp_valid, 0);
    wait_ready(-1, n);
    chk("rst_pend_sweep", n, DEPTH);

    // Clear during a sweep does not extend it.
    cyc(1, 0, 0, 0, '0, '0, '0);
    wait_ready(50, n);
    chk("clr_in_sweep", n, DEPTH);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       a = ADDR_W'($urandom_range(0, DBG_WORDS - 1) * BE_W);
      else if (r < 12) a = ADDR_W'($urandom_range(0, DEPTH - 1) * BE_W);
      else if (r == 12) a = ADDR_W'($urandom_range(0, DEPTH * BE_W - 1) | 1);
      else if (r == 13) a = ADDR_W'($urandom_range(DEPTH, 2 * DEPTH - 1) * BE_W);
      else if (r == 14) a = ADDR_W'($urandom_range(0, DEPTH - 1) * BE_W) | 32'h8000_0000;
      else              a = ADDR_W'($urandom_range(0, DEPTH - 1) * BE_W);
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a,
          DATA_W'($urandom), BE_W'($urandom_range(0, 15)));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
